// File: rtl/clk_pkg.sv
// Shared widths, limits and state encoding for the BCD set-value loader.
// Also holds the digit-position helpers that mark field boundaries.
package clk_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned DAY_W  = 5;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned YEAR_W = 14;
  localparam int unsigned ACC_W  = 14;

  localparam int unsigned NUM_DIGITS = 14;
  localparam int unsigned SHADOW_W   = 4 * NUM_DIGITS;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned DAY_MIN  = 1;
  localparam int unsigned DAY_MAX  = 31;
  localparam int unsigned MON_MIN  = 1;
  localparam int unsigned MON_MAX  = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StConv  = 2'd1,
    StCheck = 2'd2
  } state_e;

  // Digit order: sec T,U; min T,U; hour T,U; day T,U; mon T,U; year Th,H,T,U.
  function automatic logic field_first(input logic [3:0] idx);
    return (idx <= 4'd10) && !idx[0];
  endfunction

  function automatic logic field_last(input logic [3:0] idx);
    return ((idx <= 4'd9) && idx[0]) || (idx == 4'd13);
  endfunction

endpackage

// File: rtl/bcd_clk_loader_if.sv
// Set-value bus between the digit-entry UI (master) and the BCD loader (slave).
interface bcd_clk_loader_if;
  import clk_pkg::*;

  logic              start;
  logic [7:0]        digit_sec;
  logic [7:0]        digit_min;
  logic [7:0]        digit_hour;
  logic [7:0]        digit_day;
  logic [7:0]        digit_mon;
  logic [15:0]       digit_year;
  logic              busy;
  logic              done;
  logic              err;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic [DAY_W-1:0]  day;
  logic [MON_W-1:0]  mon;
  logic [YEAR_W-1:0] year;

  modport master (
    output start, digit_sec, digit_min, digit_hour, digit_day, digit_mon, digit_year,
    input  busy, done, err, sec, min, hour, day, mon, year
  );

  modport slave (
    input  start, digit_sec, digit_min, digit_hour, digit_day, digit_mon, digit_year,
    output busy, done, err, sec, min, hour, day, mon, year
  );

endinterface

// File: rtl/bcd_mac10.sv
// Shift-add decimal multiply-accumulate: res = acc * 10 + digit, truncated to 14 bits.
module bcd_mac10 (
  input  logic [13:0] acc_i,
  input  logic [3:0]  digit_i,
  output logic [13:0] res_o
);

  always_comb begin
    res_o = (acc_i << 3) + (acc_i << 1) + {10'd0, digit_i};
  end

endmodule

// File: rtl/bcd_clk_loader.sv
// Converts captured BCD set values to binary one digit per clock, range-checks them and
// loads all six time fields atomically only when the whole entry is valid.
module bcd_clk_loader
  import clk_pkg::*;
#(
  parameter bit          CHECK_RANGE = 1'b1,
  parameter int unsigned YEAR_MAX    = 9999
) (
  input logic             clk,
  input logic             rst_n,
  bcd_clk_loader_if.slave ld
);

  localparam logic [6:0]  SecMax  = 7'(SEC_MAX);
  localparam logic [6:0]  MinMax  = 7'(MIN_MAX);
  localparam logic [6:0]  HourMax = 7'(HOUR_MAX);
  localparam logic [6:0]  DayMin  = 7'(DAY_MIN);
  localparam logic [6:0]  DayMax  = 7'(DAY_MAX);
  localparam logic [6:0]  MonMin  = 7'(MON_MIN);
  localparam logic [6:0]  MonMax  = 7'(MON_MAX);
  localparam logic [13:0] YearMax = 14'(YEAR_MAX);

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                bad_q, bad_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Two-digit staging is 7 bits so out-of-range values such as 99 are not aliased.
  logic [6:0]  sec_s_q, sec_s_d, min_s_q, min_s_d, hour_s_q, hour_s_d;
  logic [6:0]  day_s_q, day_s_d, mon_s_q, mon_s_d;
  logic [13:0] year_s_q, year_s_d;

  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [DAY_W-1:0]  day_q, day_d;
  logic [MON_W-1:0]  mon_q, mon_d;
  logic [YEAR_W-1:0] year_q, year_d;

  logic [3:0]       nib [16];
  logic [3:0]       digit;
  logic [ACC_W-1:0] mac_in, mac_out;
  logic             range_err;

  always_comb begin
    for (int i = 0; i < 16; i++) nib[i] = '0;
    for (int i = 0; i < NUM_DIGITS; i++) nib[i] = shadow_q[SHADOW_W-1-4*i -: 4];
  end

  assign digit  = nib[idx_q];
  assign mac_in = field_first(idx_q) ? '0 : acc_q;

  bcd_mac10 u_mac (
    .acc_i   (mac_in),
    .digit_i (digit),
    .res_o   (mac_out)
  );

  always_comb begin
    range_err = bad_q;
    if (CHECK_RANGE) begin
      range_err = bad_q || (sec_s_q > SecMax) || (min_s_q > MinMax) || (hour_s_q > HourMax) ||
                  (day_s_q < DayMin) || (day_s_q > DayMax) ||
                  (mon_s_q < MonMin) || (mon_s_q > MonMax) || (year_s_q > YearMax);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    bad_d    = bad_q;
    done_d   = 1'b0;
    err_d    = err_q;
    sec_s_d  = sec_s_q;
    min_s_d  = min_s_q;
    hour_s_d = hour_s_q;
    day_s_d  = day_s_q;
    mon_s_d  = mon_s_q;
    year_s_d = year_s_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    day_d    = day_q;
    mon_d    = mon_q;
    year_d   = year_q;

    unique case (state_q)
      StIdle: begin
        if (ld.start) begin
          shadow_d = {ld.digit_sec, ld.digit_min, ld.digit_hour, ld.digit_day, ld.digit_mon,
                      ld.digit_year};
          err_d    = 1'b0;
          bad_d    = 1'b0;
          idx_d    = 4'd0;
          state_d  = StConv;
        end
      end
      StConv: begin
        acc_d = mac_out;
        if (digit > 4'd9) bad_d = 1'b1;
        if (field_last(idx_q)) begin
          case (idx_q)
            4'd1:    sec_s_d  = mac_out[6:0];
            4'd3:    min_s_d  = mac_out[6:0];
            4'd5:    hour_s_d = mac_out[6:0];
            4'd7:    day_s_d  = mac_out[6:0];
            4'd9:    mon_s_d  = mac_out[6:0];
            default: year_s_d = mac_out;
          endcase
        end
        if (idx_q == 4'(NUM_DIGITS - 1)) begin
          state_d = StCheck;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StCheck: begin
        done_d  = 1'b1;
        err_d   = range_err;
        state_d = StIdle;
        if (!range_err) begin
          sec_d  = sec_s_q[SEC_W-1:0];
          min_d  = min_s_q[MIN_W-1:0];
          hour_d = hour_s_q[HOUR_W-1:0];
          day_d  = day_s_q[DAY_W-1:0];
          mon_d  = mon_s_q[MON_W-1:0];
          year_d = year_s_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      bad_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sec_s_q  <= '0;
      min_s_q  <= '0;
      hour_s_q <= '0;
      day_s_q  <= '0;
      mon_s_q  <= '0;
      year_s_q <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hour_q   <= '0;
      day_q    <= '0;
      mon_q    <= '0;
      year_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      bad_q    <= bad_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sec_s_q  <= sec_s_d;
      min_s_q  <= min_s_d;
      hour_s_q <= hour_s_d;
      day_s_q  <= day_s_d;
      mon_s_q  <= mon_s_d;
      year_s_q <= year_s_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      day_q    <= day_d;
      mon_q    <= mon_d;
      year_q   <= year_d;
    end
  end

  assign ld.busy = (state_q != StIdle);
  assign ld.done = done_q;
  assign ld.err  = err_q;
  assign ld.sec  = sec_q;
  assign ld.min  = min_q;
  assign ld.hour = hour_q;
  assign ld.day  = day_q;
  assign ld.mon  = mon_q;
  assign ld.year = year_q;

endmodule

// File: tb/tb_bcd_clk_loader.sv
// Directed bench for bcd_clk_loader: conversions, error hold, ignored starts,
// mid-conversion reset and back-to-back start in the done cycle.
module tb_bcd_clk_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ndone;
  int   at;

  always #5 clk = ~clk;

  bcd_clk_loader_if ld ();

  bcd_clk_loader #(
    .CHECK_RANGE (1'b1),
    .YEAR_MAX    (9999)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dig(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                         input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
    ld.digit_sec  = s;
    ld.digit_min  = m;
    ld.digit_hour = h;
    ld.digit_day  = d;
    ld.digit_mon  = mo;
    ld.digit_year = y;
  endtask

  task automatic pulse_start();
    ld.start = 1'b1;
    tick();
    ld.start = 1'b0;
  endtask

  // Called right after the capture edge; done must follow 15 edges later.
  task automatic wait_done(input string tag);
    int cnt = 0;
    while (ld.done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, " latency"}, cnt, 15);
  endtask

  task automatic chk_out(input string tag, input int es, input int em, input int eh,
                         input int ed, input int emo, input int ey, input int eerr);
    chk({tag, " done"}, 32'(ld.done), 1);
    chk({tag, " err"},  32'(ld.err),  eerr);
    chk({tag, " sec"},  32'(ld.sec),  es);
    chk({tag, " min"},  32'(ld.min),  em);
    chk({tag, " hour"}, 32'(ld.hour), eh);
    chk({tag, " day"},  32'(ld.day),  ed);
    chk({tag, " mon"},  32'(ld.mon),  emo);
    chk({tag, " year"}, 32'(ld.year), ey);
  endtask

  task automatic run(input string tag, input logic [7:0] s, input logic [7:0] m,
                     input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                     input logic [15:0] y);
    set_dig(s, m, h, d, mo, y);
    pulse_start();
    wait_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ld.start = 1'b0;
    set_dig(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);

    // Reset state
    #12;
    chk("rst busy", 32'(ld.busy), 0);
    chk("rst done", 32'(ld.done), 0);
    chk("rst err",  32'(ld.err),  0);
    chk("rst sec",  32'(ld.sec),  0);
    chk("rst year", 32'(ld.year), 0);
    rst_n = 1'b1;
    tick();

    // Maximum valid entry
    set_dig(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h9999);
    pulse_start();
    chk("max busy", 32'(ld.busy), 1);
    wait_done("max");
    chk_out("max", 59, 59, 23, 31, 12, 9999, 0);
    chk("max busy at done", 32'(ld.busy), 0);
    tick();
    chk("max done one cycle", 32'(ld.done), 0);

    // Minimum valid entry
    run("min", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h0000);
    chk_out("min", 0, 0, 0, 1, 1, 0, 0);

    // Preload, then error entries must leave outputs untouched
    run("pre", 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h9999);
    chk_out("pre", 59, 59, 23, 31, 12, 9999, 0);
    run("nib", 8'h59, 8'h5A, 8'h23, 8'h31, 8'h12, 16'h9999);
    chk_out("nib", 59, 59, 23, 31, 12, 9999, 1);
    run("mon13", 8'h59, 8'h59, 8'h23, 8'h31, 8'h13, 16'h9999);
    chk_out("mon13", 59, 59, 23, 31, 12, 9999, 1);
    run("hour24", 8'h00, 8'h00, 8'h24, 8'h01, 8'h01, 16'h2000);
    chk_out("hour24", 59, 59, 23, 31, 12, 9999, 1);
    run("day0", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 16'h2000);
    chk_out("day0", 59, 59, 23, 31, 12, 9999, 1);
    run("sec60", 8'h60, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000);
    chk_out("sec60", 59, 59, 23, 31, 12, 9999, 1);

    // Reset at CONV index 7 with err=1 and non-zero outputs
    set_dig(8'h09, 8'h08, 8'h07, 8'h28, 8'h02, 16'h1999);
    pulse_start();
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst busy", 32'(ld.busy), 0);
    chk("mrst done", 32'(ld.done), 0);
    chk("mrst err",  32'(ld.err),  0);
    chk("mrst sec",  32'(ld.sec),  0);
    chk("mrst min",  32'(ld.min),  0);
    chk("mrst hour", 32'(ld.hour), 0);
    chk("mrst day",  32'(ld.day),  0);
    chk("mrst mon",  32'(ld.mon),  0);
    chk("mrst year", 32'(ld.year), 0);
    #3;
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_done("post rst");
    chk_out("post rst", 9, 8, 7, 28, 2, 1999, 0);

    // start re-asserted at cycles 3 and 10 is ignored
    set_dig(8'h05, 8'h43, 8'h21, 8'h30, 8'h11, 16'h2000);
    pulse_start();
    ndone = 0;
    at = 0;
    for (int i = 1; i <= 30; i++) begin
      ld.start = (i == 3 || i == 10);
      tick();
      if (ld.done === 1'b1) begin
        ndone++;
        at = i;
      end
    end
    ld.start = 1'b0;
    chk("ign done count", ndone, 1);
    chk("ign done edge", at, 15);
    chk("ign sec",  32'(ld.sec),  5);
    chk("ign min",  32'(ld.min),  43);
    chk("ign hour", 32'(ld.hour), 21);
    chk("ign day",  32'(ld.day),  30);
    chk("ign mon",  32'(ld.mon),  11);
    chk("ign year", 32'(ld.year), 2000);
    chk("ign err",  32'(ld.err),  0);

    // Back-to-back: second start in the done cycle, inputs scrambled after capture
    run("b2b a", 8'h03, 8'h02, 8'h01, 8'h04, 8'h05, 16'h0678);
    chk_out("b2b a", 3, 2, 1, 4, 5, 678, 0);
    set_dig(8'h56, 8'h34, 8'h12, 8'h15, 8'h06, 16'h2024);
    pulse_start();
    set_dig(8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 16'h1111);
    wait_done("b2b b");
    chk_out("b2b b", 56, 34, 12, 15, 6, 2024, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
